pmips_fetch_unit: RTL and testbench
===================================

Name: pmips_fetch_unit

Overview:
- IF stage of PMIPSL0: owns the PC, drives instruction-memory address, loads the IF/ID pipeline register that the Control block decodes (opcode = IF/ID[15:13]).
- Honours the Control block's PCStall; takes branch redirects from the EX/MEM stage and squashes the wrong-path fetch with a bubble.
- Keeps saturating fetch and stall counters for debug readout.

Parameters:
- PC_WIDTH, 16, PC and address width (byte address; instructions 16-bit, PC steps by 2).
- RESET_PC, 16'h0000, PC value loaded on reset.
- NOP_INSTR, 16'h0000, bubble encoding (R-type add $0,$0,$0; harmless).
- CNT_WIDTH, 16, width of each debug counter.

Ports:
- clock  in  1  system clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- pc_stall  in  1  PCStall from Control; hold PC and IF/ID.
- branch_taken  in  1  Branch AND ALU zero from EX/MEM; redirect request.
- branch_target  in  PC_WIDTH  redirect address; bit 0 ignored (forced 0).
- imem_addr  out  PC_WIDTH  instruction-memory address, equals pc combinationally.
- imem_data  in  16  instruction word, combinational read of imem_addr.
- pc  out  PC_WIDTH  current PC register.
- ifid_instr  out  16  IF/ID instruction register.
- ifid_pc_plus2  out  PC_WIDTH  PC+2 of the instruction in IF/ID (branch base).
- ifid_valid  out  1  1 = IF/ID holds a real fetched instruction, 0 = bubble.
- fetch_count  out  CNT_WIDTH  instructions loaded into IF/ID, saturating.
- stall_count  out  CNT_WIDTH  cycles with pc_stall=1 and no redirect, saturating.
- redirect_pending  out  1  high for the bubble cycle after a redirect (FSM in REDIRECT).

Behaviour:
- Reset (sync, clock edge with reset=1, overrides all else): pc=RESET_PC, ifid_instr=NOP_INSTR, ifid_pc_plus2=0, ifid_valid=0, fetch_count=0, stall_count=0, FSM=RUN, redirect_pending=0.
- FSM states: RUN, STALL, REDIRECT. Per-edge priority: reset > branch_taken > pc_stall > normal fetch.
- branch_taken=1 (any state): pc<=branch_target&~1; ifid_instr<=NOP_INSTR; ifid_valid<=0; ifid_pc_plus2 unchanged; fetch_count unchanged; stall_count unchanged; next state REDIRECT.
- Else pc_stall=1: pc, ifid_instr, ifid_pc_plus2, ifid_valid all hold; stall_count += 1 (saturate at all-ones); next state STALL.
- Else (normal fetch): ifid_instr<=imem_data; ifid_pc_plus2<=pc+2; ifid_valid<=1; pc<=pc+2; fetch_count += 1 (saturate); next state RUN.
- REDIRECT is transient: next edge follows the same priority rules (fetch from target, stall, or another redirect). redirect_pending = (state==REDIRECT).
- Latency: instruction at address A appears in IF/ID one edge after pc==A with no stall or redirect. A redirect costs exactly one bubble.
- Arithmetic: pc+2 is modulo 2^PC_WIDTH, so 0xFFFE wraps to 0x0000 with no flag. ifid_pc_plus2 wraps identically.
- Counters saturate at all-ones and never wrap. They are cleared only by reset.
- Simultaneous branch_taken and pc_stall: redirect wins; stall_count does not increment.
- Reset asserted mid-stall or mid-redirect: reset values next edge regardless of inputs.
- X on imem_data is propagated only on a normal fetch; IF/ID never samples imem_data during a stall or redirect.

Test Plan:
- Reset, then 4 free-running cycles with imem[0,2,4,6]=16'h6A01,16'h0123,16'hA402,16'h4203 -> ifid_instr follows that sequence one cycle behind pc; pc=0x0008; fetch_count=4; ifid_valid=1.
- Hold pc_stall=1 for 3 cycles after IF/ID holds 16'h0123 -> pc, ifid_instr and ifid_pc_plus2=0x0004 frozen; stall_count=3; fetch resumes at 0x0004.
- branch_taken=1, branch_target=0x0031 while pc=0x0010 -> next edge pc=0x0030, ifid_instr=0x0000, ifid_valid=0, redirect_pending=1; following edge ifid_instr=imem[0x30], ifid_pc_plus2=0x0032.
- branch_taken=1 and pc_stall=1 together -> redirect taken; stall_count unchanged; state REDIRECT.
- RESET_PC=16'hFFFC, free-run -> pc sequence FFFC, FFFE, 0000; ifid_pc_plus2 of the FFFE fetch = 0x0000.
- CNT_WIDTH=4: 20 stall cycles, then reset asserted mid-stall -> stall_count saturates at 15, then all outputs return to reset values one edge after reset.

Source files
------------

// File: rtl/pmips_fetch_unit_if.sv
// Instruction-memory bus between the PMIPSL0 fetch unit (master) and the
// instruction memory (slave); the read is combinational on imem_addr.
interface pmips_fetch_unit_if #(
  parameter int PC_WIDTH = 16
);
  logic [PC_WIDTH-1:0] imem_addr;
  logic [15:0]         imem_data;

  modport master (output imem_addr, input imem_data);
  modport slave  (input imem_addr, output imem_data);
endinterface

// File: rtl/pmips_fetch_unit.sv
// PMIPSL0 IF stage: owns the PC, loads the IF/ID register, honours PCStall,
// takes EX/MEM branch redirects with a one-bubble squash, keeps debug counters.
module pmips_fetch_unit #(
  parameter int                  PC_WIDTH  = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC  = 16'h0000,
  parameter logic [15:0]         NOP_INSTR = 16'h0000,
  parameter int                  CNT_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 pc_stall,
  input  logic                 branch_taken,
  input  logic [PC_WIDTH-1:0]  branch_target,
  pmips_fetch_unit_if.master   imem,
  output logic [PC_WIDTH-1:0]  pc,
  output logic [15:0]          ifid_instr,
  output logic [PC_WIDTH-1:0]  ifid_pc_plus2,
  output logic                 ifid_valid,
  output logic [CNT_WIDTH-1:0] fetch_count,
  output logic [CNT_WIDTH-1:0] stall_count,
  output logic                 redirect_pending
);

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_STALL    = 2'd1;
  localparam logic [1:0] ST_REDIRECT = 2'd2;

  localparam logic [PC_WIDTH-1:0]  PC_STEP   = {{(PC_WIDTH-2){1'b0}}, 2'b10};
  localparam logic [PC_WIDTH-1:0]  ALIGN_MSK = {{(PC_WIDTH-1){1'b1}}, 1'b0};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]           state_r,      state_s;
  logic [PC_WIDTH-1:0]  pc_r,         pc_s;
  logic [15:0]          instr_r,      instr_s;
  logic [PC_WIDTH-1:0]  pc_plus2_r,   pc_plus2_s;
  logic                 valid_r,      valid_s;
  logic [CNT_WIDTH-1:0] fetch_cnt_r,  fetch_cnt_s;
  logic [CNT_WIDTH-1:0] stall_cnt_r,  stall_cnt_s;
  logic                 redirect_r,   redirect_s;
  logic [PC_WIDTH-1:0]  pc_inc_s;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    if (&v) begin
      sat_inc = v;
    end else begin
      sat_inc = v + CNT_ONE;
    end
  endfunction

  assign pc_inc_s       = pc_r + PC_STEP;
  assign imem.imem_addr = pc_r;

  // Next-state selection: redirect beats stall beats normal fetch
  always_comb begin
    state_s     = state_r;
    pc_s        = pc_r;
    instr_s     = instr_r;
    pc_plus2_s  = pc_plus2_r;
    valid_s     = valid_r;
    fetch_cnt_s = fetch_cnt_r;
    stall_cnt_s = stall_cnt_r;
    if (branch_taken) begin
      state_s = ST_REDIRECT;
      pc_s    = branch_target & ALIGN_MSK;
      instr_s = NOP_INSTR;
      valid_s = 1'b0;
    end else if (pc_stall) begin
      state_s     = ST_STALL;
      stall_cnt_s = sat_inc(stall_cnt_r);
    end else begin
      // imem_data is only sampled here, so X never leaks in on stall/redirect
      state_s     = ST_RUN;
      instr_s     = imem.imem_data;
      pc_plus2_s  = pc_inc_s;
      valid_s     = 1'b1;
      pc_s        = pc_inc_s;
      fetch_cnt_s = sat_inc(fetch_cnt_r);
    end
  end

  // Registered redirect flag decoded from the upcoming state
  always_comb begin
    redirect_s = 1'b0;
    case (state_s)
      ST_RUN:      redirect_s = 1'b0;
      ST_STALL:    redirect_s = 1'b0;
      ST_REDIRECT: redirect_s = 1'b1;
      default:     redirect_s = 1'b0;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= ST_RUN;
      pc_r        <= RESET_PC;
      instr_r     <= NOP_INSTR;
      pc_plus2_r  <= {PC_WIDTH{1'b0}};
      valid_r     <= 1'b0;
      fetch_cnt_r <= {CNT_WIDTH{1'b0}};
      stall_cnt_r <= {CNT_WIDTH{1'b0}};
      redirect_r  <= 1'b0;
    end else begin
      state_r     <= state_s;
      pc_r        <= pc_s;
      instr_r     <= instr_s;
      pc_plus2_r  <= pc_plus2_s;
      valid_r     <= valid_s;
      fetch_cnt_r <= fetch_cnt_s;
      stall_cnt_r <= stall_cnt_s;
      redirect_r  <= redirect_s;
    end
  end

  assign pc               = pc_r;
  assign ifid_instr       = instr_r;
  assign ifid_pc_plus2    = pc_plus2_r;
  assign ifid_valid       = valid_r;
  assign fetch_count      = fetch_cnt_r;
  assign stall_count      = stall_cnt_r;
  assign redirect_pending = redirect_r;

endmodule

// File: tb/tb_pmips_fetch_unit.sv
// Bench for pmips_fetch_unit: two instances (default, and RESET_PC=FFFC with
// 4-bit counters) share random stimulus and are checked against a behavioural model.
module tb_pmips_fetch_unit;

  logic        clock;
  logic        reset;
  logic        pc_stall;
  logic        branch_taken;
  logic [15:0] branch_target;

  logic [15:0] mem [0:255];

  int checks = 0;
  int errors = 0;
  bit model_on = 1'b0;

  // u0: default parameters
  pmips_fetch_unit_if #(.PC_WIDTH(16)) if0 ();
  logic [15:0] pc0, instr0, pp20, fc0, sc0;
  logic        valid0, rp0;

  pmips_fetch_unit u0 (
    .clock(clock), .reset(reset), .pc_stall(pc_stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem(if0.master), .pc(pc0), .ifid_instr(instr0),
    .ifid_pc_plus2(pp20), .ifid_valid(valid0), .fetch_count(fc0), .stall_count(sc0),
    .redirect_pending(rp0)
  );

  // u1: wrapping reset PC, narrow saturating counters
  pmips_fetch_unit_if #(.PC_WIDTH(16)) if1 ();
  logic [15:0] pc1, instr1, pp21;
  logic [3:0]  fc1, sc1;
  logic        valid1, rp1;

  pmips_fetch_unit #(.RESET_PC(16'hFFFC), .CNT_WIDTH(4)) u1 (
    .clock(clock), .reset(reset), .pc_stall(pc_stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem(if1.master), .pc(pc1), .ifid_instr(instr1),
    .ifid_pc_plus2(pp21), .ifid_valid(valid1), .fetch_count(fc1), .stall_count(sc1),
    .redirect_pending(rp1)
  );

  assign if0.imem_data = mem[if0.imem_addr[8:1]];
  assign if1.imem_data = mem[if1.imem_addr[8:1]];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural model state, one entry per instance
  logic [15:0] m_pc    [2];
  logic [15:0] m_instr [2];
  logic [15:0] m_pp2   [2];
  logic        m_valid [2];
  int          m_fc    [2];
  int          m_sc    [2];
  logic        m_rp    [2];
  logic [15:0] rst_pc  [2] = '{16'h0000, 16'hFFFC};
  int          cmax    [2] = '{65535, 15};

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_pc[i] = rst_pc[i]; m_instr[i] = 16'h0000; m_pp2[i] = 16'h0000;
        m_valid[i] = 1'b0; m_fc[i] = 0; m_sc[i] = 0; m_rp[i] = 1'b0;
      end else if (branch_taken) begin
        m_pc[i] = {branch_target[15:1], 1'b0};
        m_instr[i] = 16'h0000; m_valid[i] = 1'b0; m_rp[i] = 1'b1;
      end else if (pc_stall) begin
        if (m_sc[i] < cmax[i]) m_sc[i]++;
        m_rp[i] = 1'b0;
      end else begin
        m_instr[i] = mem[m_pc[i][8:1]];
        m_pc[i] = m_pc[i] + 16'h0002;
        m_pp2[i] = m_pc[i];
        m_valid[i] = 1'b1;
        if (m_fc[i] < cmax[i]) m_fc[i]++;
        m_rp[i] = 1'b0;
      end
    end
    if (reset) model_on = 1'b1;
  endtask

  task automatic cmp_inst(input int i, input logic [15:0] p, input logic [15:0] a,
                          input logic [15:0] ins, input logic [15:0] pp2, input logic v,
                          input logic [15:0] fc, input logic [15:0] sc, input logic rp);
    check($sformatf("u%0d.pc", i), p, m_pc[i]);
    check($sformatf("u%0d.imem_addr", i), a, m_pc[i]);
    check($sformatf("u%0d.ifid_instr", i), ins, m_instr[i]);
    check($sformatf("u%0d.ifid_pc_plus2", i), pp2, m_pp2[i]);
    check($sformatf("u%0d.ifid_valid", i), {15'd0, v}, {15'd0, m_valid[i]});
    check($sformatf("u%0d.fetch_count", i), fc, 16'(m_fc[i]));
    check($sformatf("u%0d.stall_count", i), sc, 16'(m_sc[i]));
    check($sformatf("u%0d.redirect_pending", i), {15'd0, rp}, {15'd0, m_rp[i]});
  endtask

  // Cycle-by-cycle comparison against the model, away from the active edge
  always @(negedge clock) begin
    if (model_on) begin
      cmp_inst(0, pc0, if0.imem_addr, instr0, pp20, valid0, fc0, sc0, rp0);
      cmp_inst(1, pc1, if1.imem_addr, instr1, pp21, valid1, {12'd0, fc1}, {12'd0, sc1}, rp1);
    end
  end

  task automatic cyc(input logic r, input logic st, input logic br, input logic [15:0] tgt);
    reset = r; pc_stall = st; branch_taken = br; branch_target = tgt;
    @(posedge clock);
    model_step();
    #1;
  endtask

  initial begin
    for (int k = 0; k < 256; k++) mem[k] = 16'($urandom);
    mem[0] = 16'h6A01; mem[1] = 16'h0123; mem[2] = 16'hA402; mem[3] = 16'h4203;
    mem[8'h18] = 16'hBEEF;
    reset = 1'b0; pc_stall = 1'b0; branch_taken = 1'b0; branch_target = 16'h0000;
    #2;

    // Reset then free-run four fetches
    cyc(1'b1, 1'b0, 1'b0, 16'h0000);
    check("rst.pc", pc0, 16'h0000);
    check("rst.instr", instr0, 16'h0000);
    check("rst.valid", {15'd0, valid0}, 16'h0000);
    check("rst.fetch", fc0, 16'h0000);
    check("rst.pc_u1", pc1, 16'hFFFC);
    cyc(1'b0, 1'b0, 1'b0, 16'h0000);
    check("run1.instr", instr0, 16'h6A01);
    check("wrap.pc_fffe", pc1, 16'hFFFE);
    cyc(1'b0, 1'b0, 1'b0, 16'h0000);
    check("run2.instr", instr0, 16'h0123);
    check("wrap.pc_0000", pc1, 16'h0000);
    check("wrap.pp2", pp21, 16'h0000);
    cyc(1'b0, 1'b0, 1'b0, 16'h0000);
    cyc(1'b0, 1'b0, 1'b0, 16'h0000);
    check("run4.instr", instr0, 16'h4203);
    check("run4.pc", pc0, 16'h0008);
    check("run4.fetch", fc0, 16'h0004);
    check("run4.valid", {15'd0, valid0}, 16'h0001);

    // Stall three cycles with 0123 in IF/ID
    cyc(1'b1, 1'b0, 1'b0, 16'h0000);
    cyc(1'b0, 1'b0, 1'b0, 16'h0000);
    cyc(1'b0, 1'b0, 1'b0, 16'h0000);
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b1, 1'b0, 16'h0000);
    check("stall.pc", pc0, 16'h0004);
    check("stall.instr", instr0, 16'h0123);
    check("stall.pp2", pp20, 16'h0004);
    check("stall.count", sc0, 16'h0003);
    cyc(1'b0, 1'b0, 1'b0, 16'h0000);
    check("resume.instr", instr0, 16'hA402);
    check("resume.pp2", pp20, 16'h0006);

    // Redirect from pc=0x0010 to 0x0031 (aligned to 0x0030)
    for (int k = 0; k < 5; k++) cyc(1'b0, 1'b0, 1'b0, 16'h0000);
    check("pre_br.pc", pc0, 16'h0010);
    cyc(1'b0, 1'b0, 1'b1, 16'h0031);
    check("br.pc", pc0, 16'h0030);
    check("br.instr", instr0, 16'h0000);
    check("br.valid", {15'd0, valid0}, 16'h0000);
    check("br.pending", {15'd0, rp0}, 16'h0001);
    cyc(1'b0, 1'b0, 1'b0, 16'h0000);
    check("br_fetch.instr", instr0, 16'hBEEF);
    check("br_fetch.pp2", pp20, 16'h0032);
    check("br_fetch.pending", {15'd0, rp0}, 16'h0000);

    // Branch and stall together: redirect wins, stall_count unchanged
    cyc(1'b0, 1'b1, 1'b1, 16'h0100);
    check("br_stall.pc", pc0, 16'h0100);
    check("br_stall.count", sc0, 16'h0003);
    check("br_stall.pending", {15'd0, rp0}, 16'h0001);

    // Saturation with 4-bit counters, then reset mid-stall
    cyc(1'b1, 1'b0, 1'b0, 16'h0000);
    for (int k = 0; k < 20; k++) cyc(1'b0, 1'b1, 1'b0, 16'h0000);
    check("sat.u1", {12'd0, sc1}, 16'h000F);
    check("sat.u0", sc0, 16'h0014);
    cyc(1'b1, 1'b1, 1'b1, 16'h0200);
    check("rst_mid.u1_sc", {12'd0, sc1}, 16'h0000);
    check("rst_mid.u1_pc", pc1, 16'hFFFC);
    check("rst_mid.u0_pc", pc0, 16'h0000);
    check("rst_mid.u0_pending", {15'd0, rp0}, 16'h0000);

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      cyc(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0,
          ($urandom_range(0, 99) < 30) ? 1'b1 : 1'b0,
          ($urandom_range(0, 99) < 10) ? 1'b1 : 1'b0,
          16'($urandom));
    end

    @(negedge clock);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
